sobel_edge_pipe: RTL and testbench

Parametrised, fully pipelined Sobel edge detector for the D8M camera video path, with line width, pixel depth, gradient mode and threshold configurable. It accepts RGB pixels with valid/start-of-line/start-of-frame qualifiers and builds a 3x3 window from two internal line buffers. It converts the window to luma and emits a thresholded edge magnitude with a matching valid strobe. It sits between the camera RGB stream and the cartoon/overlay mixers, replacing the fixed 640-column, always-on detector.

---
 rtl/sobel_edge_pipe_if.sv | 20 ++
 rtl/sobel_edge_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_sobel_edge_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_pipe_if.sv
// Pixel/edge stream bundle for sobel_edge_pipe: the video source uses master, the detector uses slave.
interface sobel_edge_pipe_if #(
  parameter int DATA_W   = 8,
  parameter int THRESH_W = 8
);
  logic                in_valid;
  logic                in_sol;
  logic                in_sof;
  logic [3*DATA_W-1:0] in_rgb;
  logic [1:0]          mode;
  logic [THRESH_W-1:0] thresh;
  logic                out_valid;
  logic [DATA_W-1:0]   out_edge;
  logic [3*DATA_W-1:0] out_rgb;

  modport master (output in_valid, in_sol, in_sof, in_rgb, mode, thresh,
                  input  out_valid, out_edge, out_rgb);
  modport slave  (input  in_valid, in_sol, in_sof, in_rgb, mode, thresh,
                  output out_valid, out_edge, out_rgb);
endinterface

// File: rtl/sobel_edge_pipe.sv
// 3x3 Sobel edge detector: line-buffer read, window shift, luma, gradient/threshold (4-cycle latency).
// Define SOBEL_CENTER_RGB_EN to emit the window-centre RGB on out_rgb instead of a grey edge map.

module sobel_edge_luma #(
  parameter int DATA_W = 8
) (
  input  logic [3*DATA_W-1:0] rgb,
  output logic [DATA_W-1:0]   y
);
  localparam int YW = DATA_W + 8;
  logic [YW-1:0] sum;
  // Coefficients add up to 255, so the upper DATA_W bits can never overflow.
  assign sum = YW'(rgb[3*DATA_W-1:2*DATA_W]) * YW'(54)
             + YW'(rgb[2*DATA_W-1:DATA_W])   * YW'(183)
             + YW'(rgb[DATA_W-1:0])          * YW'(18);
  assign y = sum[YW-1:8];
endmodule

module sobel_edge_pipe #(
  parameter int DATA_W   = 8,
  parameter int LINE_W   = 640,
  parameter int COL_W    = 10,
  parameter int THRESH_W = 8
) (
  input logic             clk,
  input logic             rst,
  sobel_edge_pipe_if.slave px
);
  localparam int PW     = 3 * DATA_W;
  localparam int GW     = DATA_W + 3;
  localparam int AW     = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int MW     = (DATA_W > THRESH_W) ? DATA_W : THRESH_W;
  localparam int STAGES = 4;
  localparam logic [GW:0] MAXV = (GW+1)'((1 << DATA_W) - 1);

  typedef struct packed {
    logic [PW-1:0] cur;
    logic [PW-1:0] up1;
    logic [PW-1:0] up2;
    logic          bord;
  } s1_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             sof_seen_q, sof_seen_d;
  logic             acc;
  logic [AW-1:0]    addr;

  logic [STAGES:1]  vld_q, vld_d;
  logic [STAGES:0]  vld_pipe;

  logic [PW-1:0] lb0_mem [LINE_W];
  logic [PW-1:0] lb1_mem [LINE_W];

  s1_t                     s1_q, s1_d;
  logic [2:0][2:0][PW-1:0] win_q, win_d;
  logic                    bord2_q, bord2_d;
  logic [8:0][DATA_W-1:0]  luma_q, luma_d;
  logic                    bord3_q, bord3_d;

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay;
  logic [GW:0]          mag;
  logic [DATA_W-1:0]    sat, edge_q, edge_d;

  function automatic logic signed [GW-1:0] sx(input logic [DATA_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  // Pixels arriving after reset are ignored until a frame start re-aligns the counters.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    sof_seen_d = sof_seen_q | (px.in_valid & px.in_sof);
    acc        = px.in_valid & (px.in_sof | sof_seen_q);
    if (acc) begin
      if (px.in_sof) begin
        col_d = '0;
        row_d = '0;
      end else if (px.in_sol) begin
        col_d = '0;
        if (row_q != 2'd2) row_d = row_q + 2'd1;
      end else if (col_q != COL_W'(LINE_W - 1)) begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign addr     = col_d[AW-1:0];
  assign vld_pipe = {vld_q, acc};
  assign vld_d    = vld_pipe[STAGES-1:0];

  // Buffer 0 holds the line above, buffer 1 the line above that; both read before write.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0_mem[addr] <= px.in_rgb;
      lb1_mem[addr] <= lb0_mem[addr];
    end
  end

  always_comb begin
    s1_d = s1_q;
    if (acc) begin
      s1_d.cur  = px.in_rgb;
      s1_d.up1  = lb0_mem[addr];
      s1_d.up2  = lb1_mem[addr];
      s1_d.bord = (row_d < 2'd2) || (col_d < COL_W'(2));
    end
  end

  // Window [row][col]: row 0 is oldest line, col 2 is newest pixel.
  always_comb begin
    win_d   = win_q;
    bord2_d = bord2_q;
    if (vld_pipe[1]) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = s1_q.up2;
      win_d[1][2] = s1_q.up1;
      win_d[2][2] = s1_q.cur;
      bord2_d     = s1_q.bord;
    end
  end

  for (genvar i = 0; i < 9; i++) begin : g_luma
    sobel_edge_luma #(.DATA_W(DATA_W)) u_luma (
      .rgb (win_q[i/3][i%3]),
      .y   (luma_d[i])
    );
  end

  assign bord3_d = bord2_q;

  always_comb begin
    gx = (sx(luma_q[2]) - sx(luma_q[0]))
       + ((sx(luma_q[5]) - sx(luma_q[3])) <<< 1)
       + (sx(luma_q[8]) - sx(luma_q[6]));
    gy = (sx(luma_q[0]) - sx(luma_q[6]))
       + ((sx(luma_q[1]) - sx(luma_q[7])) <<< 1)
       + (sx(luma_q[2]) - sx(luma_q[8]));
    ax  = $unsigned(gx[GW-1] ? -gx : gx);
    ay  = $unsigned(gy[GW-1] ? -gy : gy);
    mag = '0;
    case (px.mode)
      2'd0:    mag = {1'b0, ax} + {1'b0, ay};
      2'd1:    mag = {1'b0, ax};
      2'd2:    mag = {1'b0, ay};
      default: mag = (ax > ay) ? {1'b0, ax} : {1'b0, ay};
    endcase
    sat    = (mag > MAXV) ? '1 : mag[DATA_W-1:0];
    edge_d = (bord3_q || (MW'(sat) <= MW'(px.thresh))) ? '0 : sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      sof_seen_q <= 1'b0;
      vld_q      <= '0;
      s1_q       <= '0;
      win_q      <= '0;
      bord2_q    <= 1'b0;
      luma_q     <= '0;
      bord3_q    <= 1'b0;
      edge_q     <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      sof_seen_q <= sof_seen_d;
      vld_q      <= vld_d;
      s1_q       <= s1_d;
      win_q      <= win_d;
      bord2_q    <= bord2_d;
      luma_q     <= luma_d;
      bord3_q    <= bord3_d;
      edge_q     <= edge_d;
    end
  end

  assign px.out_valid = vld_pipe[STAGES];
  assign px.out_edge  = edge_q;

`ifdef SOBEL_CENTER_RGB_EN
  logic [PW-1:0] ctr3_q, ctr3_d, rgb4_q, rgb4_d;
  assign ctr3_d = win_q[1][1];
  assign rgb4_d = ctr3_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr3_q <= '0;
      rgb4_q <= '0;
    end else begin
      ctr3_q <= ctr3_d;
      rgb4_q <= rgb4_d;
    end
  end
  assign px.out_rgb = rgb4_q;
`else
  assign px.out_rgb = {3{edge_q}};
`endif

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Self-checking bench for sobel_edge_pipe: step/flat frame table, random frames with gaps, mid-frame reset.
module tb_sobel_edge_pipe;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int CW = 4;
  localparam int TW = 8;
  localparam int NV = 11;

  typedef struct {
    logic [7:0]  edge_v;
    logic [23:0] rgb;
    bit          chk_rgb;
    int          cyc;
    int          r;
    int          c;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] lo;
    logic [7:0] hi;
    int         md;
    int         th;
    logic [7:0] e_step;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  string cur = "init";

  exp_t        expq[$];
  logic [23:0] frm [0:7][0:LW-1];
  vec_t        vt [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_edge_pipe_if #(.DATA_W(DW), .THRESH_W(TW)) bus ();

  sobel_edge_pipe #(.DATA_W(DW), .LINE_W(LW), .COL_W(CW), .THRESH_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .px  (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout in %s", cur);
    $fatal(1);
  end

  function automatic int luma(input logic [23:0] p);
    return (54 * int'(p[23:16]) + 183 * int'(p[15:8]) + 18 * int'(p[7:0])) / 256;
  endfunction

  // Reference: Sobel on the luma of the frame pixels around (r-1, c-1), straight from frame indices.
  function automatic logic [7:0] model_edge(input int r, input int c, input int md, input int th);
    int l[9];
    int gx, gy, ax, ay, m;
    if (r < 2 || c < 2) return 8'd0;
    for (int i = 0; i < 9; i++) l[i] = luma(frm[r-2+i/3][c-2+i%3]);
    gx = (l[2] - l[0]) + 2 * (l[5] - l[3]) + (l[8] - l[6]);
    gy = (l[0] - l[6]) + 2 * (l[1] - l[7]) + (l[2] - l[8]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      0:       m = ax + ay;
      1:       m = ax;
      2:       m = ay;
      default: m = (ax > ay) ? ax : ay;
    endcase
    if (m > 255) m = 255;
    return (m <= th) ? 8'd0 : 8'(m);
  endfunction

  function automatic exp_t mk_exp(input int r, input int c, input int md, input int th, input int tbl);
    exp_t e;
    e.r = r;
    e.c = c;
    e.cyc = 0;
    if (tbl < 0) e.edge_v = model_edge(r, c, md, th);
    else         e.edge_v = (r >= 2 && (c == 8 || c == 9)) ? vt[tbl].e_step : 8'd0;
`ifdef SOBEL_CENTER_RGB_EN
    e.rgb     = (r >= 1 && c >= 1) ? frm[r-1][c-1] : 24'd0;
    e.chk_rgb = (r >= 2 && c >= 2);
`else
    e.rgb     = {3{e.edge_v}};
    e.chk_rgb = 1'b1;
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  // One clock: sample outputs at the falling edge, then the caller drives new inputs.
  task automatic tick();
    exp_t e;
    int   lat;
    @(negedge clk);
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected out_valid edge=%0d", cur, bus.out_edge);
      end else begin
        e   = expq.pop_front();
        lat = cyc - e.cyc;
        if (bus.out_edge !== e.edge_v || lat != 4 || (e.chk_rgb && bus.out_rgb !== e.rgb)) begin
          errors++;
          $display("FAIL %s r%0d c%0d edge got %0d want %0d rgb got %h want %h latency got %0d want 4",
                   cur, e.r, e.c, bus.out_edge, e.edge_v, bus.out_rgb, e.rgb, lat);
        end
      end
    end
  endtask

  task automatic idle();
    tick();
    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_px(input logic [23:0] rgb, input bit sol, input bit sof, input exp_t e, input bit want);
    exp_t q;
    tick();
    bus.in_valid = 1'b1;
    bus.in_rgb   = rgb;
    bus.in_sol   = sol;
    bus.in_sof   = sof;
    if (want) begin
      q = e;
      q.cyc = cyc;
      expq.push_back(q);
    end
  endtask

  task automatic run_rows(input int r0, input int r1, input int ncol, input int md, input int th,
                          input int unsigned gapmax, input int tbl, input bit with_sof);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < ncol; c++) begin
        if (gapmax > 0) repeat ($urandom_range(gapmax)) idle();
        send_px(frm[r][c], c == 0, with_sof && r == 0 && c == 0, mk_exp(r, c, md, th, tbl), with_sof);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (expq.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    chk({cur, "_drain"}, 32'(expq.size()), 0);
  endtask

  task automatic fill_step(input logic [7:0] lo, input logic [7:0] hi);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < LW; c++) frm[r][c] = (c < 8) ? {3{lo}} : {3{hi}};
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < LW; c++) frm[r][c] = 24'($urandom);
  endtask

  initial begin
    vt[0]  = '{"flat",          8'd100, 8'd100, 0, 19,  8'd0};
    vt[1]  = '{"vstep_m1",      8'd0,   8'd200, 1, 19,  8'd255};
    vt[2]  = '{"vstep_m2",      8'd0,   8'd200, 2, 19,  8'd0};
    vt[3]  = '{"vstep_m3",      8'd0,   8'd200, 3, 19,  8'd255};
    vt[4]  = '{"small_th19",    8'd0,   8'd4,   0, 19,  8'd0};
    vt[5]  = '{"small_th10",    8'd0,   8'd4,   0, 10,  8'd12};
    vt[6]  = '{"small_m3_th11", 8'd0,   8'd4,   3, 11,  8'd12};
    vt[7]  = '{"small_m1_th12", 8'd0,   8'd4,   1, 12,  8'd0};
    vt[8]  = '{"sat_th254",     8'd0,   8'd200, 0, 254, 8'd255};
    vt[9]  = '{"sat_th255",     8'd0,   8'd200, 0, 255, 8'd0};
    vt[10] = '{"rstep_m1",      8'd200, 8'd0,   1, 19,  8'd255};

    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_rgb   = '0;
    bus.mode     = 2'd0;
    bus.thresh   = '0;

    cur = "reset";
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_edge",  32'(bus.out_edge),  0);
    chk("reset_out_rgb",   32'(bus.out_rgb),   0);
    #2 rst = 1'b0;
    idle();

    for (int t = 0; t < NV; t++) begin
      cur = vt[t].name;
      fill_step(vt[t].lo, vt[t].hi);
      bus.mode   = 2'(vt[t].md);
      bus.thresh = 8'(vt[t].th);
      run_rows(0, 4, LW, vt[t].md, vt[t].th, 0, t, 1'b1);
      drain();
    end

    for (int k = 0; k < 4; k++) begin
      int th;
      cur = $sformatf("rand%0d", k);
      th  = int'($urandom_range(40));
      fill_rand();
      bus.mode   = 2'(k);
      bus.thresh = 8'(th);
      run_rows(0, 6, LW, k, th, 3, -1, 1'b1);
      drain();
    end

    cur = "midrst";
    fill_rand();
    bus.mode   = 2'd0;
    bus.thresh = 8'd10;
    run_rows(0, 5, LW, 0, 10, 1, -1, 1'b1);
    run_rows(5, 6, 8, 0, 10, 0, -1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid_drop", 32'(bus.out_valid), 0);
    chk("midrst_edge_clear", 32'(bus.out_edge),  0);
    expq.delete();
    idle();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("midrst_hold_valid", 32'(bus.out_valid), 0);
    end
    #2 rst = 1'b0;

    cur = "post_rst_nosof";
    fill_rand();
    run_rows(0, 1, LW, 0, 10, 0, -1, 1'b0);
    repeat (8) idle();

    cur = "post_rst_frame";
    run_rows(0, 4, LW, 0, 10, 1, -1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
